test_mode_low_tester: RTL and testbench
=======================================

# test_mode_low_tester

Self-checking stimulus/response partner for the 2x2 low-density test-mode design. Drives its serial inputs `a`/`b` from an LFSR and watches its four outputs. Holds a cycle-accurate model of that design and compares every cycle. Reports pass/fail, an error count and an optional MISR signature. Used on-fabric and in simulation as the driving/checking end of the test-mode benchmarks.

## Interface
- `N_VECTORS`, 256: number of compared RUN cycles. Range 1..65535.
- `SEED`, 16'hACE1: LFSR seed. A value of 0 is replaced by 16'h0001.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  begin a test; sampled only in IDLE.
- `dut_out`  in  4  DUT outputs {out4,out3,out2,out1}; bit0 = out1.
- `a`  out  1  DUT input a; registered.
- `b`  out  1  DUT input b; registered.
- `busy`  out  1  high in FLUSH/LOAD/RUN/DONE.
- `done`  out  1  one-cycle pulse in DONE.
- `pass`  out  1  valid from DONE until the next start: 1 iff err_count==0.
- `err_count`  out  8  mismatching RUN cycles; saturates at 255.
- `signature`  out  16  MISR of dut_out over RUN; see Configuration.

## Operation
- **Model registers:** pa[1:0], pb[1:0], ps[3:0], mirroring the DUT.
- **Model shift:** each cycle pa <= {pa[0], a}; pb <= {pb[0], b}.
- **Model next state** (all sums 2-bit; c1, c3, c5 = carry bits):
  - s0 = pa[1]+pb[1]+ps[3]
  - s1 = ps[0]+s0[1]+ps[2]
  - s2 = ps[1]+s1[1]+ps[3]
  - s3 = ps[2]+s2[1]+ps[0]
  - ps <= {s3[0], s2[0], s1[0], s0[0]}
- **LFSR:** 16-bit Fibonacci, shift left, feedback l[15]^l[13]^l[12]^l[10]. Advances once per RUN cycle only.
- **FSM:**
  - IDLE: a=b=0. start → FLUSH; clear err_count, pass, signature; reload LFSR with SEED.
  - FLUSH: 2 cycles, a=b=0. Clears the DUT's input pipes; model pa/pb also go to 0.
  - LOAD: 1 cycle, a=b=0. Model ps <= next-state function evaluated on dut_out (not model ps) with pa=pb=0. This resynchronises to any DUT state.
  - RUN: N_VECTORS cycles.
    - a <= l[0], b <= l[1]; model updates normally.
    - Compare dut_out against model ps; on mismatch err_count += 1 (saturating).
  - DONE: 1 cycle. done=1; pass <= (err_count==0); then → IDLE.
- A RUN-cycle counter (16-bit) ends RUN. No other exit except rst.
- start outside IDLE is ignored; it is not queued.

## Timing
- **Reset values:**
  - a=0, b=0, busy=0, done=0, pass=0, err_count=0, signature=0.
  - FSM=IDLE, LFSR=SEED, model registers=0.
- **Cycle numbering:** start sampled in cycle 0.
  - FLUSH: cycles 1-2.
  - LOAD: cycle 3.
  - RUN: cycles 4 .. 3+N_VECTORS.
  - done pulse: cycle 4+N_VECTORS.
- busy rises in cycle 1 and falls in cycle 5+N_VECTORS.
- err_count is live during RUN, updated the cycle after each compare. It is final in DONE.
- **rst mid-operation:** immediate return to reset values. The DUT keeps stale state; the next start resynchronises via FLUSH/LOAD.
- **start together with rst:** rst wins.
- **err_count saturation:** holds at 255; pass=0.

## Configuration
- `TEST_MODE_LOW_TESTER_MISR_EN` defined:
  - signature is a 16-bit MISR, same polynomial as the LFSR.
  - dut_out is XORed into bits [3:0] each RUN cycle.
  - Frozen after RUN, cleared on start.
- Undefined: signature tied to 16'h0000 and no MISR logic is instantiated. Pass/fail behaviour is unchanged.

## Test plan
- rst, then start with a fault-free DUT connected, N_VECTORS=256 → done in cycle 260, pass=1, err_count=0.
- Force dut_out[2]=0 for the whole run → pass=0, 0 < err_count ≤ 255. A DUT held at all ones for 256 cycles → err_count=255.
- start asserted again at cycles 2, 3 and 100 → ignored; done still only in cycle 260.
- rst at RUN cycle 100 (DUT left non-zero), then start → pass=1, err_count=0.
- N_VECTORS=1 → busy cycles 1-5, done in cycle 5, exactly one compare.
- MISR_EN, two runs with the same SEED → identical non-zero signature. A single injected bit flip → different signature. MISR_EN undefined → signature=0.

Source files
------------

// File: rtl/test_mode_low_tester.sv
// rtl/test_mode_low_tester.sv - LFSR-driven stimulus/checker for the 2x2 test-mode design; MISR signature under TEST_MODE_LOW_TESTER_MISR_EN
module test_mode_low_tester #(
    parameter int unsigned N_VECTORS = 256,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  dut_out,
    output logic        a,
    output logic        b,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  err_count,
    output logic [15:0] signature
);
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] LAST_RUN = 16'(N_VECTORS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FLUSH = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state, state_nx;
    logic [15:0] cnt;
    logic [15:0] lfsr;
    logic [1:0]  pa, pb;
    logic [3:0]  ps;

    function automatic logic [15:0] poly_step(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    // Ripple of 2-bit adders; only the carries of s0..s2 propagate, s3 needs just its sum bit.
    function automatic logic [3:0] model_next(input logic pa1, input logic pb1, input logic [3:0] s);
        logic [1:0] s0, s1, s2;
        logic       s3;
        s0 = {1'b0, pa1}  + {1'b0, pb1}   + {1'b0, s[3]};
        s1 = {1'b0, s[0]} + {1'b0, s0[1]} + {1'b0, s[2]};
        s2 = {1'b0, s[1]} + {1'b0, s1[1]} + {1'b0, s[3]};
        s3 = s[2] ^ s2[1] ^ s[0];
        return {s3, s2[0], s1[0], s0[0]};
    endfunction

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_FLUSH;
            S_FLUSH: if (cnt[0]) state_nx = S_LOAD;
            S_LOAD:  state_nx = S_RUN;
            S_RUN:   if (cnt == LAST_RUN) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 16'd0;
            lfsr      <= SEED_EFF;
            a         <= 1'b0;
            b         <= 1'b0;
            pass      <= 1'b0;
            err_count <= 8'd0;
            pa        <= 2'd0;
            pb        <= 2'd0;
            ps        <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= (state_nx != state) ? 16'd0 : cnt + 16'd1;
            a     <= 1'b0;
            b     <= 1'b0;
            pa    <= {pa[0], a};
            pb    <= {pb[0], b};
            ps    <= model_next(pa[1], pb[1], ps);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        err_count <= 8'd0;
                        pass      <= 1'b0;
                        lfsr      <= SEED_EFF;
                    end
                end
                S_FLUSH: begin
                    pa <= 2'd0;
                    pb <= 2'd0;
                end
                // Adopt whatever state the DUT is in; its input pipes are already zero here.
                S_LOAD: ps <= model_next(1'b0, 1'b0, dut_out);
                S_RUN: begin
                    a    <= lfsr[0];
                    b    <= lfsr[1];
                    lfsr <= poly_step(lfsr);
                    if ((dut_out != ps) && (err_count != 8'hFF))
                        err_count <= err_count + 8'd1;
                end
                S_DONE: pass <= (err_count == 8'd0);
                default: ;
            endcase
        end
    end

`ifdef TEST_MODE_LOW_TESTER_MISR_EN
    logic [15:0] misr;

    always_ff @(posedge clk) begin
        if (rst)
            misr <= 16'd0;
        else if ((state == S_IDLE) && start)
            misr <= 16'd0;
        else if (state == S_RUN)
            misr <= poly_step(misr) ^ {12'd0, dut_out};
    end

    assign signature = misr;
`else
    assign signature = 16'h0000;
`endif

endmodule

// File: tb/tb_test_mode_low_tester.sv
// tb/tb_test_mode_low_tester.sv - random-fault bench for test_mode_low_tester with golden 2x2 DUT and cycle reference
module tb_test_mode_low_tester;
    logic        clk = 1'b0;
    logic        rst;
    logic        start_s [2];
    logic [3:0]  dout    [2];
    logic        a_o     [2];
    logic        b_o     [2];
    logic        busy_o  [2];
    logic        done_o  [2];
    logic        pass_o  [2];
    logic [7:0]  err_o   [2];
    logic [15:0] sig_o   [2];

    logic [1:0]  gpa [2];
    logic [1:0]  gpb [2];
    logic [3:0]  gps [2];
    logic        gclr;
    int          fault   [2];
    logic [3:0]  flip    [2];
    logic        ovr_en  [2];
    logic [3:0]  ovr_val [2];

    int n_vec = 0;
    int n_bad = 0;
    int errs;
    int rc;

    always #5 clk = ~clk;

    test_mode_low_tester #(.N_VECTORS(256), .SEED(16'hACE1)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_s[0]), .dut_out(dout[0]),
        .a(a_o[0]), .b(b_o[0]), .busy(busy_o[0]), .done(done_o[0]),
        .pass(pass_o[0]), .err_count(err_o[0]), .signature(sig_o[0])
    );

    test_mode_low_tester #(.N_VECTORS(1), .SEED(16'h0000)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .dut_out(dout[1]),
        .a(a_o[1]), .b(b_o[1]), .busy(busy_o[1]), .done(done_o[1]),
        .pass(pass_o[1]), .err_count(err_o[1]), .signature(sig_o[1])
    );

    function automatic logic [15:0] step16(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    function automatic logic [3:0] model_ps(input bit pa1, input bit pb1, input logic [3:0] s);
        int t0, t1, t2, t3;
        t0 = int'(pa1) + int'(pb1) + int'(s[3]);
        t1 = int'(s[0]) + t0 / 2 + int'(s[2]);
        t2 = int'(s[1]) + t1 / 2 + int'(s[3]);
        t3 = int'(s[2]) + t2 / 2 + int'(s[0]);
        return 4'((t3 % 2) * 8 + (t2 % 2) * 4 + (t1 % 2) * 2 + (t0 % 2));
    endfunction

    function automatic logic [3:0] present(input logic [3:0] s, input int mode);
        return (mode == 1) ? (s & 4'b1011) : s;
    endfunction

    function automatic logic [15:0] seed_of(input int inst);
        return (inst == 0) ? 16'hACE1 : 16'h0001;
    endfunction

    // Golden fault-free DUT; never reset by rst, only by the bench power-on clear.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (gclr) begin
                gpa[i] <= 2'b00;
                gpb[i] <= 2'b00;
                gps[i] <= 4'h9;
            end else begin
                gpa[i] <= {gpa[i][0], a_o[i]};
                gpb[i] <= {gpb[i][0], b_o[i]};
                gps[i] <= model_ps(gpa[i][1], gpb[i][1], gps[i]);
            end
        end
    end

    assign dout[0] = ovr_en[0] ? ovr_val[0] : (present(gps[0], fault[0]) ^ flip[0]);
    assign dout[1] = ovr_en[1] ? ovr_val[1] : (present(gps[1], fault[1]) ^ flip[1]);

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle_values(input int inst);
        expect_eq("rst_a",    32'(a_o[inst]),    32'd0);
        expect_eq("rst_b",    32'(b_o[inst]),    32'd0);
        expect_eq("rst_busy", 32'(busy_o[inst]), 32'd0);
        expect_eq("rst_done", 32'(done_o[inst]), 32'd0);
        expect_eq("rst_pass", 32'(pass_o[inst]), 32'd0);
        expect_eq("rst_err",  32'(err_o[inst]),  32'd0);
        expect_eq("rst_sig",  32'(sig_o[inst]),  32'd0);
    endtask

    // mode: 0 clean, 1 out3 stuck at 0, 3 always present the complement of the expected state.
    task automatic run_test(input int inst, input int nv, input int mode, input int flip_c,
                            input int x0, input int x1, input int x2, output int n_err);
        bit          ea[];
        bit          eb[];
        logic [15:0] l, ms, exp_sig;
        logic [3:0]  rps, seen, fmask;
        ea = new[nv + 8];
        eb = new[nv + 8];
        l = seed_of(inst);
        for (int c = 0; c < nv + 8; c++) begin
            if (c >= 5 && c <= 4 + nv) begin
                ea[c] = l[0];
                eb[c] = l[1];
                l = step16(l);
            end else begin
                ea[c] = 1'b0;
                eb[c] = 1'b0;
            end
        end
        fmask = 4'(1 << $urandom_range(0, 3));
        n_err = 0;
        ms    = 16'd0;
        rps   = 4'd0;
        fault[inst] = mode;
        @(negedge clk);
        expect_eq("idle_busy", 32'(busy_o[inst]), 32'd0);
        start_s[inst] = 1'b1;
        for (int c = 1; c <= nv + 6; c++) begin
            @(negedge clk);
            start_s[inst] = (c == x0) || (c == x1) || (c == x2);
            flip[inst]    = (c == flip_c) ? fmask : 4'd0;
            ovr_en[inst]  = (mode == 3) && (c >= 4) && (c <= 3 + nv);
            ovr_val[inst] = ~rps;
            #1;
            expect_eq("busy", 32'(busy_o[inst]), 32'(c <= 4 + nv));
            expect_eq("done", 32'(done_o[inst]), 32'(c == 4 + nv));
            expect_eq("a",    32'(a_o[inst]),    32'(ea[c]));
            expect_eq("b",    32'(b_o[inst]),    32'(eb[c]));
            expect_eq("err",  32'(err_o[inst]),  32'((n_err > 255) ? 255 : n_err));
            if (c >= 5 + nv) begin
`ifdef TEST_MODE_LOW_TESTER_MISR_EN
                exp_sig = ms;
`else
                exp_sig = 16'h0000;
`endif
                expect_eq("pass", 32'(pass_o[inst]), 32'(n_err == 0));
                expect_eq("sig",  32'(sig_o[inst]),  32'(exp_sig));
            end
            seen = dout[inst];
            if (c == 3) begin
                rps = model_ps(1'b0, 1'b0, seen);
            end else if (c >= 4 && c <= 3 + nv) begin
                if (seen != rps) n_err++;
                ms  = step16(ms) ^ {12'd0, seen};
                rps = model_ps(ea[c - 2], eb[c - 2], rps);
            end
        end
        start_s[inst] = 1'b0;
        flip[inst]    = 4'd0;
        ovr_en[inst]  = 1'b0;
        fault[inst]   = 0;
    endtask

    initial begin
        rst  = 1'b1;
        gclr = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0;
            fault[i]   = 0;
            flip[i]    = 4'd0;
            ovr_en[i]  = 1'b0;
            ovr_val[i] = 4'd0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        gclr = 1'b0;
        check_idle_values(0);
        check_idle_values(1);

        // start coinciding with rst must not launch a test
        start_s[0] = 1'b1;
        @(negedge clk);
        expect_eq("rst_wins", 32'(busy_o[0]), 32'd0);
        rst = 1'b0;
        start_s[0] = 1'b0;
        @(negedge clk);
        expect_eq("rst_wins_idle", 32'(busy_o[0]), 32'd0);

        run_test(0, 256, 0, -1, 2, 3, 100, errs);
        expect_eq("clean_errs", 32'(err_o[0]), 32'd0);

        run_test(0, 256, 1, -1, -1, -1, $urandom_range(5, 259), errs);
        expect_eq("stuck_err_pos", 32'(err_o[0] != 8'd0), 32'd1);

        run_test(0, 256, 3, -1, -1, -1, -1, errs);
        expect_eq("err_saturate", 32'(err_o[0]), 32'd255);

        run_test(0, 256, 0, $urandom_range(4, 259), -1, -1, -1, errs);
        expect_eq("flip_one_err", 32'(err_o[0]), 32'd1);

        // reset partway through RUN, leaving the DUT with stale state
        rc = $urandom_range(5, 250);
        @(negedge clk);
        start_s[0] = 1'b1;
        for (int c = 1; c <= rc; c++) begin
            @(negedge clk);
            start_s[0] = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_values(0);
        run_test(0, 256, 0, -1, -1, -1, -1, errs);

        run_test(1, 1, 0, -1, -1, -1, -1, errs);
        run_test(1, 1, 3, -1, 2, -1, -1, errs);
        expect_eq("n1_one_compare", 32'(err_o[1]), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
